// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute-to-memory pipeline boundary:
// widths, the zero register, flag bit positions and the MEM control bundle.
package alu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef logic [3:0] flags_t;

  typedef struct packed {
    logic valid;
    logic regWrite;
    logic memRead;
    logic memWrite;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // A bubble carries no side effects, and a write to XZR is discarded.
  function automatic ctrl_t gateCtrl(input logic             valid,
                                     input logic             regWrite,
                                     input logic [REG_W-1:0] rd,
                                     input logic             memRead,
                                     input logic             memWrite);
    ctrl_t c;
    c.valid    = valid;
    c.regWrite = valid && regWrite && (rd != XZR);
    c.memRead  = valid && memRead;
    c.memWrite = valid && memWrite;
    return c;
  endfunction

endpackage

// File: rtl/dff_en.sv
// Width-parameterised enabled D flip-flop with synchronous active-high reset.
module dff_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/alu_ex_mem_stage.sv
// EX/MEM pipeline register with architectural NZVC flag register.
// Optional macro FLAG_BYPASS_EN forwards ex_flags combinationally onto flags.
module alu_ex_mem_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [3:0]        ex_flags,
  input  logic              ex_set_flags,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [REG_W-1:0]  mem_rd,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [3:0]        flags
);

  logic              w_advance;
  logic              w_capture;
  logic              w_flagLoad;
  ctrl_t             w_ctrlNext;
  logic [REG_W-1:0]  w_rdNext;
  logic [DATA_W-1:0] w_resultNext;
  logic [DATA_W-1:0] w_storeNext;

  ctrl_t             r_ctrl;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_storeData;
  flags_t            r_flags;

  assign w_advance  = !reset && !stall && !flush;
  // Flush overrides stall and loads zeros; reset is applied inside dff_en.
  assign w_capture  = w_advance || flush;
  assign w_flagLoad = w_advance && ex_valid && ex_set_flags;

  assign w_ctrlNext   = flush ? '0 : gateCtrl(ex_valid, ex_reg_write, ex_rd,
                                              ex_mem_read, ex_mem_write);
  assign w_rdNext     = flush ? '0 : ex_rd;
  assign w_resultNext = flush ? '0 : ex_result;
  assign w_storeNext  = flush ? '0 : ex_store_data;

  dff_en #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .reset(reset), .en(w_capture), .d(w_ctrlNext), .q(r_ctrl)
  );

  dff_en #(.W(REG_W)) u_rd (
    .clk(clk), .reset(reset), .en(w_capture), .d(w_rdNext), .q(r_rd)
  );

  dff_en #(.W(DATA_W)) u_result (
    .clk(clk), .reset(reset), .en(w_capture), .d(w_resultNext), .q(r_result)
  );

  dff_en #(.W(DATA_W)) u_storeData (
    .clk(clk), .reset(reset), .en(w_capture), .d(w_storeNext), .q(r_storeData)
  );

  dff_en #(.W(4)) u_flags (
    .clk(clk), .reset(reset), .en(w_flagLoad), .d(ex_flags), .q(r_flags)
  );

  assign mem_valid      = r_ctrl.valid;
  assign mem_reg_write  = r_ctrl.regWrite;
  assign mem_mem_read   = r_ctrl.memRead;
  assign mem_mem_write  = r_ctrl.memWrite;
  assign mem_rd         = r_rd;
  assign mem_result     = r_result;
  assign mem_store_data = r_storeData;

`ifdef FLAG_BYPASS_EN
  assign flags = w_flagLoad ? ex_flags : r_flags;
`else
  assign flags = r_flags;
`endif

endmodule
